// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: drives the PLL reset, waits for lock with bounded
// retries, qualifies lock stability, then releases the system reset.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       MAX_R    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_PLLRST = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [3:0]       retry_nxt;
    logic [7:0]       loss_nxt;
    logic             lk_p0, lk_p1;
    logic             lk;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Stage p0/p1: two-flop synchronizer for the asynchronous lock pin
    always_ff @(posedge refclk) begin
        if (rst) begin
            lk_p0 <= 1'b0;
            lk_p1 <= 1'b0;
        end else begin
            lk_p0 <= pll_locked;
            lk_p1 <= lk_p0;
        end
    end

    assign lk = lk_p1;

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q + CNT_W'(1);
        retry_nxt = retry_cnt;
        loss_nxt  = loss_cnt;
        case (state_q)
            ST_PLLRST: begin
                if (cnt_q == RST_LAST) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end
            end
            ST_WAIT: begin
                // A lock arriving on the timeout cycle takes priority
                if (lk) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_nxt = '0;
                    if (retry_cnt == MAX_R) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        retry_nxt = retry_cnt + 4'd1;
                        state_nxt = ST_PLLRST;
                    end
                end
            end
            ST_STABLE: begin
                if (!lk) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end else if (cnt_q == STB_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                    retry_nxt = 4'd0;
                end
            end
            ST_RUN: begin
                cnt_nxt = '0;
                if (!lk) begin
                    state_nxt = ST_PLLRST;
                    loss_nxt  = sat_inc8(loss_cnt);
                end
            end
            ST_FAULT: begin
                cnt_nxt = '0;
            end
            default: begin
                state_nxt = ST_PLLRST;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they flip on the same edge as state
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_PLLRST;
            cnt_q     <= '0;
            retry_cnt <= 4'd0;
            loss_cnt  <= 8'd0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            retry_cnt <= retry_nxt;
            loss_cnt  <= loss_nxt;
            pll_rst   <= (state_nxt == ST_PLLRST) || (state_nxt == ST_FAULT);
            sys_rst   <= (state_nxt != ST_RUN);
            ready     <= (state_nxt == ST_RUN);
            fault     <= (state_nxt == ST_FAULT);
        end
    end

    assign state = state_q;

endmodule
